// File: rtl/wb_rr_arbiter_4.sv
// wb_rr_arbiter_4: four-master Wishbone round-robin arbiter with per-grant ack timeout
module wb_rr_arbiter_4 #(
    parameter int DATAW   = 32,
    parameter int ADDRW   = 20,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         wbm_cyc_i,
    input  logic [3:0]         wbm_stb_i,
    input  logic [3:0]         wbm_we_i,
    input  logic [4*ADDRW-1:0] wbm_adr_i,
    input  logic [4*DATAW-1:0] wbm_dat_i,
    output logic [DATAW-1:0]   wbm_dat_o,
    output logic [3:0]         wbm_ack_o,
    output logic [3:0]         wbm_err_o,
    output logic               wbs_cyc_o,
    output logic               wbs_stb_o,
    output logic               wbs_we_o,
    output logic [ADDRW-1:0]   wbs_adr_o,
    output logic [DATAW-1:0]   wbs_dat_o,
    input  logic [DATAW-1:0]   wbs_dat_i,
    input  logic               wbs_ack_i,
    output logic [3:0]         gnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t      state_q;
    logic [3:0]  gnt_q, err_q;
    logic [1:0]  last_q, win;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy, cyc_g, stb_g;
    // first requester after last_q, scanning downward so the nearest one is assigned last
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] last);
        pick = last;
        for (int k = 4; k >= 1; k--)
            if (req[last + 2'(k)]) pick = last + 2'(k);
    endfunction
    assign win   = pick(wbm_cyc_i, last_q);
    assign cnt_d = cnt_q + 8'd1;
    assign busy  = state_q == BUSY;
    assign cyc_g = wbm_cyc_i[last_q];
    assign stb_g = wbm_stb_i[last_q];
    // slave side follows the owner only while BUSY; ERR and IDLE keep the slave quiet
    always_comb begin
        wbs_cyc_o = busy & cyc_g;
        wbs_stb_o = busy & stb_g;
        wbs_we_o  = busy & wbm_we_i[last_q];
        wbs_adr_o = busy ? wbm_adr_i[last_q*ADDRW +: ADDRW] : '0;
        wbs_dat_o = busy ? wbm_dat_i[last_q*DATAW +: DATAW] : '0;
        wbm_ack_o = busy ? gnt_q & {4{wbs_ack_i}} : 4'b0;
    end
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_err_o = err_q;
    assign gnt_o     = gnt_q;
    // grant FSM; last_q doubles as the index of the current owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            err_q <= '0;
            case (state_q)
                IDLE: if (|wbm_cyc_i) begin
                    state_q <= BUSY;
                    gnt_q   <= 4'b1 << win;
                    last_q  <= win;
                    cnt_q   <= '0;
                end
                BUSY: if (!cyc_g) begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                end else if (wbs_ack_i || !stb_g) begin
                    cnt_q <= '0;
                end else if (cnt_d == TO) begin
                    state_q <= ERR;
                    err_q   <= gnt_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
                default: if (!cyc_g) begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end
endmodule
